cpu_sequencer: RTL and testbench

Instruction-level controller that sequences the `cpu` datapath (32x32 register file plus ALU with add/sub/compare).
- Accepts one operation at a time on a valid/ready command interface.
- Drives the datapath control signals `addressA`, `addressB`, `dataIn`, `asel`, `bsel`, `opsel`, `outsel` and `oen` for the required cycles.
- Captures `outPut`/`over` and returns them on a valid/ready response interface.
- Replaces hand-driven stimulus sequencing, so software or a test harness issues STORE/READ/ADD/SUB/CMP as transactions.

---
 rtl/cpu_seq_pkg.sv | 32 +++
 rtl/cpu_seq_decode.sv | 23 ++
 rtl/cpu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared opcodes, FSM state encoding and datapath control encodings for the cpu sequencer.
package cpu_seq_pkg;

    localparam logic [2:0] OP_STORE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_CMP   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] opsel;
        logic [1:0] outsel;
        logic       asel;
        logic       bsel;
    } ctrl_t;

    localparam ctrl_t CTRL_STORE = '{opsel: 2'b01, outsel: 2'b00, asel: 1'b0, bsel: 1'b0};
    localparam ctrl_t CTRL_READ  = '{opsel: 2'b01, outsel: 2'b00, asel: 1'b1, bsel: 1'b0};
    localparam ctrl_t CTRL_ADD   = '{opsel: 2'b00, outsel: 2'b01, asel: 1'b1, bsel: 1'b1};
    localparam ctrl_t CTRL_SUB   = '{opsel: 2'b01, outsel: 2'b01, asel: 1'b1, bsel: 1'b1};
    localparam ctrl_t CTRL_CMP   = '{opsel: 2'b00, outsel: 2'b10, asel: 1'b1, bsel: 1'b1};
    // The parked datapath looks like a READ so nothing is ever written while idle.
    localparam ctrl_t CTRL_IDLE  = CTRL_READ;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode decode to datapath control fields; 0 cycles, no flow control.
module cpu_seq_decode
    import cpu_seq_pkg::*;
(
    input  logic [2:0] op_i,
    output ctrl_t      ctrl_o,
    output logic       legal_o
);

    always_comb begin
        ctrl_o  = CTRL_IDLE;
        legal_o = 1'b1;
        case (op_i)
            OP_STORE: ctrl_o = CTRL_STORE;
            OP_READ:  ctrl_o = CTRL_READ;
            OP_ADD:   ctrl_o = CTRL_ADD;
            OP_SUB:   ctrl_o = CTRL_SUB;
            OP_CMP:   ctrl_o = CTRL_CMP;
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Sequences one STORE/READ/ADD/SUB/CMP at a time onto the cpu datapath; response after 1+DP_LAT cycles
// (illegal ops: 1 cycle). No command buffering: cmd_ready drops until the response is accepted.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int DP_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [DW-1:0] cmd_data,
    output logic [AW-1:0] addressA,
    output logic [AW-1:0] addressB,
    output logic [DW-1:0] dataIn,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    opsel,
    output logic [1:0]    outsel,
    output logic          oen,
    input  logic [DW-1:0] outPut,
    input  logic          over,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_over,
    output logic          rsp_err,
    output logic          busy,
    output logic [15:0]   op_count
);

    localparam logic [2:0] WAIT_LOAD = 3'(DP_LAT - 1);

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic          is_store_q;
    ctrl_t         ctrl_q;
    logic          oen_q;
    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [DW-1:0] data_in_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_over_q;
    logic          rsp_err_q;
    logic [15:0]   op_count_q;

    ctrl_t         dec_ctrl;
    logic          dec_legal;
    logic [15:0]   op_count_d;
    logic [AW-1:0] addr_b_d;
    logic [DW-1:0] data_in_d;

    cpu_seq_decode u_decode (
        .op_i    (cmd_op),
        .ctrl_o  (dec_ctrl),
        .legal_o (dec_legal)
    );

    assign op_count_d = op_count_q + 16'd1;
    assign addr_b_d   = (cmd_op == OP_READ) ? cmd_ra : cmd_rb;
    assign data_in_d  = (cmd_op == OP_STORE) ? cmd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            ctrl_q      <= CTRL_IDLE;
            oen_q       <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_in_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_over_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_store_q <= (cmd_op == OP_STORE);
                        if (dec_legal) begin
                            state_q   <= ST_ISSUE;
                            ctrl_q    <= dec_ctrl;
                            oen_q     <= 1'b1;
                            addr_a_q  <= cmd_ra;
                            addr_b_q  <= addr_b_d;
                            data_in_q <= data_in_d;
                        end else begin
                            // Illegal ops never touch the datapath; answer immediately.
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_over_q  <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_store_q) begin
                        state_q    <= ST_IDLE;
                        op_count_q <= op_count_d;
                        ctrl_q     <= CTRL_IDLE;
                        oen_q      <= 1'b0;
                        addr_a_q   <= '0;
                        addr_b_q   <= '0;
                        data_in_q  <= '0;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= outPut;
                        rsp_over_q  <= over;
                        rsp_err_q   <= 1'b0;
                        ctrl_q      <= CTRL_IDLE;
                        oen_q       <= 1'b0;
                        addr_a_q    <= '0;
                        addr_b_q    <= '0;
                        data_in_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign addressA  = addr_a_q;
    assign addressB  = addr_b_q;
    assign dataIn    = data_in_q;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign opsel     = ctrl_q.opsel;
    assign outsel    = ctrl_q.outsel;
    assign oen       = oen_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_over  = rsp_over_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench: behavioural cpu datapath stubs around a DP_LAT=1 and a DP_LAT=3 sequencer, directed table plus random ops.
module tb_cpu_sequencer;

    localparam int DP_LAT = 1;
    localparam logic [47:0] IDLE_VEC = {5'd0, 5'd0, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_ra, cmd_rb;
    logic [31:0] cmd_data;
    logic [4:0]  addressA, addressB;
    logic [31:0] dataIn;
    logic        asel, bsel, oen;
    logic [1:0]  opsel, outsel;
    logic [31:0] outPut;
    logic        over;
    logic        rsp_valid, rsp_ready, rsp_over, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [15:0] op_count;

    logic        d3_cmd_valid, d3_cmd_ready;
    logic [2:0]  d3_cmd_op;
    logic [4:0]  d3_cmd_ra, d3_cmd_rb;
    logic [31:0] d3_cmd_data;
    logic [4:0]  d3_addressA, d3_addressB;
    logic [31:0] d3_dataIn;
    logic        d3_asel, d3_bsel, d3_oen;
    logic [1:0]  d3_opsel, d3_outsel;
    logic [31:0] d3_outPut;
    logic        d3_over;
    logic        d3_rsp_valid, d3_rsp_ready, d3_rsp_over, d3_rsp_err, d3_busy;
    logic [31:0] d3_rsp_data;
    logic [15:0] d3_op_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.DW(32), .AW(5), .DP_LAT(DP_LAT)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_data(cmd_data), .addressA(addressA),
        .addressB(addressB), .dataIn(dataIn), .asel(asel), .bsel(bsel), .opsel(opsel),
        .outsel(outsel), .oen(oen), .outPut(outPut), .over(over), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_over(rsp_over), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    cpu_sequencer #(.DW(32), .AW(5), .DP_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_op(d3_cmd_op),
        .cmd_ra(d3_cmd_ra), .cmd_rb(d3_cmd_rb), .cmd_data(d3_cmd_data), .addressA(d3_addressA),
        .addressB(d3_addressB), .dataIn(d3_dataIn), .asel(d3_asel), .bsel(d3_bsel), .opsel(d3_opsel),
        .outsel(d3_outsel), .oen(d3_oen), .outPut(d3_outPut), .over(d3_over), .rsp_valid(d3_rsp_valid),
        .rsp_ready(d3_rsp_ready), .rsp_data(d3_rsp_data), .rsp_over(d3_rsp_over), .rsp_err(d3_rsp_err),
        .busy(d3_busy), .op_count(d3_op_count)
    );

    // Datapath stub: A = regfile or dataIn, B = regfile or 0; result is {over, value}.
    function automatic logic [32:0] dp_eval(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] os, input logic [1:0] ol);
        logic [32:0] r;
        r = '0;
        case (ol)
            2'b00:   r = {1'b0, a};
            2'b01:   r = (os == 2'b00) ? ({1'b0, a} + {1'b0, b}) : {a < b, a - b};
            2'b10:   r = {1'b0, 31'd0, a < b};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [31:0] rf  [32];
    logic [31:0] rf3 [32];
    logic [32:0] pipe  [DP_LAT];
    logic [32:0] pipe3 [3];

    always @(posedge clk) begin
        if (oen && !asel) rf[addressB] <= dataIn;
        pipe[0] <= dp_eval(asel ? rf[addressA] : dataIn, bsel ? rf[addressB] : 32'd0, opsel, outsel);
        for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {over, outPut} = pipe[DP_LAT-1];

    always @(posedge clk) begin
        if (d3_oen && !d3_asel) rf3[d3_addressB] <= d3_dataIn;
        pipe3[0] <= dp_eval(d3_asel ? rf3[d3_addressA] : d3_dataIn, d3_bsel ? rf3[d3_addressB] : 32'd0,
                            d3_opsel, d3_outsel);
        for (int i = 1; i < 3; i++) pipe3[i] <= pipe3[i-1];
    end
    assign {d3_over, d3_outPut} = pipe3[2];

    // Op-level reference model.
    logic [31:0] model_rf [32];
    int          model_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] drive_vec();
        return {addressA, addressB, dataIn, opsel, outsel, asel, bsel, oen};
    endfunction

    task automatic send(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] d);
        int n;
        n = 0;
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_timeout", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, input logic [31:0] ed, input logic eo, input logic ee, input int elat);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            chk("pre_rsp_oen_held", 64'(oen), 64'd1);
            @(posedge clk); #1; lat++;
        end
        chk("rsp_latency", 64'(lat), 64'(elat));
        chk("rsp_drive_idle", 64'(drive_vec()), 64'(IDLE_VEC));
        chk("rsp_fields", {31'd0, rsp_data, rsp_over, rsp_err}, {31'd0, ed, eo, ee});
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            chk("backpressure_hold", {29'd0, rsp_valid, cmd_ready, busy, rsp_data}, {29'd0, 1'b1, 1'b0, 1'b1, ed});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_release", {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    task automatic apply(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] d,
                         input int hold, input logic check_ctrl, input logic [5:0] ctrl,
                         input logic [31:0] ed, input logic eo, input logic ee);
        send(op, ra, rb, d);
        if (op > 3'd4) begin
            chk("illegal_drive_idle", 64'(drive_vec()), 64'(IDLE_VEC));
        end else if (check_ctrl) begin
            chk("issue_drive", 64'(drive_vec()),
                64'({ra, (op == 3'd1) ? ra : rb, (op == 3'd0) ? d : 32'd0, ctrl, 1'b1}));
        end
        if (op == 3'd0) begin
            @(posedge clk); #1;
            chk("store_done", {16'd0, 47'(drive_vec()), cmd_ready}, {16'd0, 47'(IDLE_VEC), 1'b1});
            model_rf[rb] = d;
        end else begin
            get_rsp(hold, ed, eo, ee, (op > 3'd4) ? 0 : 1 + DP_LAT);
        end
        model_cnt++;
        chk("op_count", 64'(op_count), 64'(model_cnt[15:0]));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  ra, rb;
        logic [31:0] data;
        int          hold;
        logic [5:0]  ctrl;
        logic [31:0] ed;
        logic        eo, ee;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [4:0]  ra, rb;
        logic [31:0] d, ed;
        logic        eo, ee;
        logic [32:0] sum;
        int          sel, lat, held, stale;

        tbl[0]  = '{3'd0, 5'd0, 5'd0, 32'h0000_0005, 0, 6'b01_00_0_0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 5'd0, 5'd3, 32'h1234_5678, 0, 6'b01_00_1_0, 32'h0000_0005, 1'b0, 1'b0};
        tbl[2]  = '{3'd0, 5'd1, 5'd5, 32'hFFFF_FFFF, 0, 6'b01_00_0_0, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{3'd0, 5'd2, 5'd8, 32'h0000_0001, 0, 6'b01_00_0_0, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{3'd2, 5'd5, 5'd8, 32'hAAAA_AAAA, 1, 6'b00_01_1_1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5]  = '{3'd0, 5'd0, 5'd2, 32'h5555_5555, 0, 6'b01_00_0_0, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{3'd0, 5'd0, 5'd4, 32'h0000_000B, 0, 6'b01_00_0_0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{3'd3, 5'd2, 5'd4, 32'h0000_0000, 5, 6'b01_01_1_1, 32'h5555_554A, 1'b0, 1'b0};
        tbl[8]  = '{3'd4, 5'd4, 5'd2, 32'h0000_0000, 0, 6'b00_10_1_1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[9]  = '{3'd7, 5'd3, 5'd4, 32'hDEAD_BEEF, 2, 6'b00_00_0_0, 32'h0, 1'b0, 1'b1};
        tbl[10] = '{3'd5, 5'd1, 5'd1, 32'h0000_0000, 0, 6'b00_00_0_0, 32'h0, 1'b0, 1'b1};
        tbl[11] = '{3'd3, 5'd8, 5'd5, 32'h0000_0000, 0, 6'b01_01_1_1, 32'h0000_0002, 1'b1, 1'b0};
        tbl[12] = '{3'd1, 5'd5, 5'd9, 32'h0000_0000, 0, 6'b01_00_1_0, 32'hFFFF_FFFF, 1'b0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_data = '0;
        d3_cmd_valid = 1'b0; d3_rsp_ready = 1'b0;
        d3_cmd_op = '0; d3_cmd_ra = '0; d3_cmd_rb = '0; d3_cmd_data = '0;
        model_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_status", {cmd_ready, rsp_valid, rsp_over, rsp_err, busy, op_count}, {5'b10000, 16'd0});
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_drive", 64'(drive_vec()), 64'(IDLE_VEC));

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].data, tbl[i].hold, 1'b1, tbl[i].ctrl,
                  tbl[i].ed, tbl[i].eo, tbl[i].ee);
        end
        chk("table_op_count", 64'(op_count), 64'd13);

        // Reset while an ADD sits in WAIT: no response may surface afterwards.
        send(3'd2, 5'd5, 5'd8, 32'd0);
        @(posedge clk); #1;
        chk("midop_in_wait", {busy, oen, rsp_valid}, 3'b110);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;
        chk("midop_reset_status", {cmd_ready, rsp_valid, busy, op_count}, {3'b100, 16'd0});
        chk("midop_reset_drive", 64'(drive_vec()), 64'(IDLE_VEC));
        stale = 0;
        repeat (6) begin @(posedge clk); #1; if (rsp_valid || busy) stale++; end
        chk("midop_no_stale_rsp", 64'(stale), 64'd0);

        for (int r = 0; r < 8; r++) begin
            d = (r % 2 == 0) ? 32'hFFFF_FFFF - 32'(r) : $urandom;
            apply(3'd0, 5'd0, 5'(r), d, 0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
        end

        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 15);
            if (sel < 5)       op = 3'd0;
            else if (sel < 7)  op = 3'd1;
            else if (sel < 10) op = 3'd2;
            else if (sel < 12) op = 3'd3;
            else if (sel < 14) op = 3'd4;
            else               op = 3'($urandom_range(5, 7));
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            ed = 32'd0; eo = 1'b0; ee = 1'b0;
            case (op)
                3'd1: ed = model_rf[ra];
                3'd2: begin sum = {1'b0, model_rf[ra]} + {1'b0, model_rf[rb]}; ed = sum[31:0]; eo = sum[32]; end
                3'd3: begin ed = model_rf[ra] - model_rf[rb]; eo = model_rf[ra] < model_rf[rb]; end
                3'd4: ed = (model_rf[ra] < model_rf[rb]) ? 32'd1 : 32'd0;
                3'd0: ;
                default: ee = 1'b1;
            endcase
            apply(op, ra, rb, d, $urandom_range(0, 2), 1'b0, 6'd0, ed, eo, ee);
        end

        // DP_LAT=3 instance: STORE 300 into r9, then READ it back.
        chk("d3_idle_ready", {d3_cmd_ready, d3_busy, d3_op_count}, {2'b10, 16'd0});
        d3_cmd_op = 3'd0; d3_cmd_ra = 5'd0; d3_cmd_rb = 5'd9; d3_cmd_data = 32'h0000_012C; d3_cmd_valid = 1'b1;
        @(posedge clk); #1;
        d3_cmd_valid = 1'b0;
        chk("d3_store_issue", {d3_opsel, d3_outsel, d3_asel, d3_bsel, d3_oen, d3_dataIn},
            {2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_012C});
        repeat (2) begin @(posedge clk); #1; end
        chk("d3_store_count", {d3_cmd_ready, d3_op_count}, {1'b1, 16'd1});
        d3_cmd_op = 3'd1; d3_cmd_ra = 5'd9; d3_cmd_rb = 5'd2; d3_cmd_valid = 1'b1;
        @(posedge clk); #1;
        d3_cmd_valid = 1'b0;
        lat = 0; held = 1;
        while (!d3_rsp_valid && lat < 20) begin
            if (!(d3_oen && d3_opsel == 2'b01 && d3_outsel == 2'b00 && d3_asel && !d3_bsel &&
                  d3_addressA == 5'd9 && d3_addressB == 5'd9)) held = 0;
            @(posedge clk); #1; lat++;
        end
        chk("d3_latency", 64'(lat), 64'd4);
        chk("d3_issue_held", 64'(held), 64'd1);
        chk("d3_rsp", {d3_rsp_data, d3_rsp_over, d3_rsp_err, d3_oen}, {32'h0000_012C, 3'b000});
        d3_rsp_ready = 1'b1;
        @(posedge clk); #1;
        d3_rsp_ready = 1'b0;
        chk("d3_done", {d3_rsp_valid, d3_cmd_ready, d3_op_count}, {2'b01, 16'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
